// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage -- load/store memory stage.
// Decodes one load/store instruction per request, checks legality and
// alignment, and runs a single request/ack transaction on a 64-bit
// big-endian memory port with a 16-cycle ack timeout.
//
// Ports
//   i_clk, i_reset            clock, synchronous active-high reset
//   i_start                   one-cycle request (ignored while busy)
//   i_opcode, i_xods          primary opcode and DS-form sub-opcode
//   i_ea, i_store_data        effective address and store source value
//   o_busy, o_done            operation in progress / one-cycle completion
//   o_load_data               extended load result (0 for stores)
//   o_err                     0 ok, 1 misaligned, 2 illegal op, 3 timeout
//   o_update                  STWU base-register update request
//   o_mem_*, i_mem_rdata/ack  memory request port
module lsu_mem_stage (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [5:0]  i_opcode,
  input  logic [1:0]  i_xods,
  input  logic [63:0] i_ea,
  input  logic [63:0] i_store_data,
  output logic        o_busy,
  output logic        o_done,
  output logic [63:0] o_load_data,
  output logic [1:0]  o_err,
  output logic        o_update,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [63:0] o_mem_addr,
  output logic [7:0]  o_mem_be,
  output logic [63:0] o_mem_wdata,
  input  logic [63:0] i_mem_rdata,
  input  logic        i_mem_ack
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // access size encoded as log2(bytes)
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef struct packed {
    logic       legal;
    logic       store;
    logic       sign;
    logic       upd;
    logic [1:0] size;
  } dec_t;

  // Opcode table; xods only qualifies the DS-form opcodes 58 and 62.
  function automatic dec_t f_decode(input logic [5:0] op, input logic [1:0] xo);
    dec_t d;
    d = '0;
    case (op)
      6'd34: d = '{1'b1, 1'b0, 1'b0, 1'b0, SZ_B};  // LBZ
      6'd40: d = '{1'b1, 1'b0, 1'b0, 1'b0, SZ_H};  // LHZ
      6'd42: d = '{1'b1, 1'b0, 1'b1, 1'b0, SZ_H};  // LHA
      6'd32: d = '{1'b1, 1'b0, 1'b0, 1'b0, SZ_W};  // LWZ
      6'd58: begin
        if (xo == 2'd0)      d = '{1'b1, 1'b0, 1'b0, 1'b0, SZ_D};  // LD
        else if (xo == 2'd2) d = '{1'b1, 1'b0, 1'b1, 1'b0, SZ_W};  // LWA
        else                 d = '0;
      end
      6'd38: d = '{1'b1, 1'b1, 1'b0, 1'b0, SZ_B};  // STB
      6'd44: d = '{1'b1, 1'b1, 1'b0, 1'b0, SZ_H};  // STH
      6'd36: d = '{1'b1, 1'b1, 1'b0, 1'b0, SZ_W};  // STW
      6'd37: d = '{1'b1, 1'b1, 1'b0, 1'b1, SZ_W};  // STWU
      6'd62: begin
        if (xo == 2'd0) d = '{1'b1, 1'b1, 1'b0, 1'b0, SZ_D};  // STD
        else            d = '0;
      end
      default: d = '0;
    endcase
    return d;
  endfunction

  function automatic logic f_misaligned(input logic [1:0] size, input logic [2:0] off);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return off[0];
      SZ_W:    return |off[1:0];
      SZ_D:    return |off;
      default: return 1'b0;
    endcase
  endfunction

  // Stores enable exactly the written lanes; loads flag only the lane of
  // the first addressed byte since the whole doubleword is returned.
  function automatic logic [7:0] f_be(input logic store, input logic [1:0] size,
                                      input logic [2:0] off);
    logic [7:0] m;
    if (!store) begin
      m = 8'h80;
    end else begin
      case (size)
        SZ_B:    m = 8'h80;
        SZ_H:    m = 8'hC0;
        SZ_W:    m = 8'hF0;
        SZ_D:    m = 8'hFF;
        default: m = 8'h00;
      endcase
    end
    return m >> off;
  endfunction

  // Replicating the low bytes places them in whichever aligned lanes are addressed.
  function automatic logic [63:0] f_wdata(input logic [1:0] size, input logic [63:0] d);
    case (size)
      SZ_B:    return {8{d[7:0]}};
      SZ_H:    return {4{d[15:0]}};
      SZ_W:    return {2{d[31:0]}};
      default: return d;
    endcase
  endfunction

  // Shift the addressed big-endian field to the top, then extend it down.
  function automatic logic [63:0] f_extract(input logic [63:0] rdata, input logic [2:0] off,
                                            input logic [1:0] size, input logic sign);
    logic [63:0] w;
    w = rdata << {off, 3'b000};
    case (size)
      SZ_B:    return {{56{sign & w[63]}}, w[63:56]};
      SZ_H:    return {{48{sign & w[63]}}, w[63:48]};
      SZ_W:    return {{32{sign & w[63]}}, w[63:32]};
      default: return w;
    endcase
  endfunction

  state_t      r_state;
  logic        r_busy, r_done, r_update, r_mem_req, r_mem_we;
  logic [1:0]  r_err;
  logic [63:0] r_load_data, r_mem_addr, r_mem_wdata;
  logic [7:0]  r_mem_be;
  logic [3:0]  r_tmo_cnt;
  // decoded attributes of the accepted instruction (stand in for opcode/xods)
  logic        r_store, r_sign, r_upd;
  logic [1:0]  r_size;
  logic [2:0]  r_off;

  dec_t w_dec;
  logic w_misaligned;

  assign w_dec        = f_decode(i_opcode, i_xods);
  assign w_misaligned = f_misaligned(w_dec.size, i_ea[2:0]);

  // Transaction FSM with all outputs registered.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_update    <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_err       <= 2'd0;
      r_load_data <= 64'd0;
      r_mem_addr  <= 64'd0;
      r_mem_wdata <= 64'd0;
      r_mem_be    <= 8'd0;
      r_tmo_cnt   <= 4'd0;
      r_store     <= 1'b0;
      r_sign      <= 1'b0;
      r_upd       <= 1'b0;
      r_size      <= 2'd0;
      r_off       <= 3'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_store <= w_dec.store;
            r_sign  <= w_dec.sign;
            r_upd   <= w_dec.upd;
            r_size  <= w_dec.size;
            r_off   <= i_ea[2:0];
            r_busy  <= 1'b1;
            if (!w_dec.legal || w_misaligned) begin
              // Early completion: illegal outranks misaligned, no memory access.
              r_state     <= ST_RESP;
              r_done      <= 1'b1;
              r_err       <= w_dec.legal ? 2'd1 : 2'd2;
              r_load_data <= 64'd0;
              r_update    <= 1'b0;
            end else begin
              r_state     <= ST_REQ;
              r_mem_req   <= 1'b1;
              r_mem_we    <= w_dec.store;
              r_mem_addr  <= {i_ea[63:3], 3'b000};
              r_mem_be    <= f_be(w_dec.store, w_dec.size, i_ea[2:0]);
              r_mem_wdata <= f_wdata(w_dec.size, i_store_data);
              r_tmo_cnt   <= 4'd0;
            end
          end
        end
        ST_REQ: begin
          if (i_mem_ack) begin
            r_state     <= ST_RESP;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= 8'd0;
            r_done      <= 1'b1;
            r_err       <= 2'd0;
            r_load_data <= r_store ? 64'd0 : f_extract(i_mem_rdata, r_off, r_size, r_sign);
            r_update    <= r_upd;
          end else if (r_tmo_cnt == 4'd15) begin
            // sixteenth REQ cycle without ack
            r_state     <= ST_RESP;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= 8'd0;
            r_done      <= 1'b1;
            r_err       <= 2'd3;
            r_load_data <= 64'd0;
            r_update    <= 1'b0;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 4'd1;
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state   <= ST_IDLE;
          r_done    <= 1'b0;
          r_busy    <= 1'b0;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_load_data = r_load_data;
  assign o_err       = r_err;
  assign o_update    = r_update;
  assign o_mem_req   = r_mem_req;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_be    = r_mem_be;
  assign o_mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb_lsu_mem_stage -- self-checking bench for lsu_mem_stage.
// Directed cases followed by randomized transactions, each compared
// against a byte-level reference model of the load/store rules.
module tb_lsu_mem_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  opcode = 6'd0;
  logic [1:0]  xods = 2'd0;
  logic [63:0] ea = 64'd0;
  logic [63:0] store_data = 64'd0;
  logic        busy, done, update, mem_req, mem_we;
  logic [63:0] load_data, mem_addr, mem_wdata;
  logic [1:0]  err;
  logic [7:0]  mem_be;
  logic [63:0] mem_rdata = 64'd0;
  logic        mem_ack = 1'b0;

  int n_vec = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  lsu_mem_stage dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_opcode(opcode), .i_xods(xods),
    .i_ea(ea), .i_store_data(store_data), .o_busy(busy), .o_done(done),
    .o_load_data(load_data), .o_err(err), .o_update(update), .o_mem_req(mem_req),
    .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_be(mem_be), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata), .i_mem_ack(mem_ack)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // Instruction table: access width in bytes, signedness, store, base update.
  task automatic ref_decode(input logic [5:0] op, input logic [1:0] xo, output bit legal,
                            output bit store, output bit sgn, output bit upd, output int nb);
    legal = 1'b1; store = 1'b0; sgn = 1'b0; upd = 1'b0; nb = 0;
    case (op)
      6'd34: nb = 1;
      6'd40: nb = 2;
      6'd42: begin nb = 2; sgn = 1'b1; end
      6'd32: nb = 4;
      6'd58: begin
        if (xo == 2'd0) nb = 8;
        else if (xo == 2'd2) begin nb = 4; sgn = 1'b1; end
        else legal = 1'b0;
      end
      6'd38: begin nb = 1; store = 1'b1; end
      6'd44: begin nb = 2; store = 1'b1; end
      6'd36: begin nb = 4; store = 1'b1; end
      6'd37: begin nb = 4; store = 1'b1; upd = 1'b1; end
      6'd62: begin
        if (xo == 2'd0) begin nb = 8; store = 1'b1; end
        else legal = 1'b0;
      end
      default: legal = 1'b0;
    endcase
  endtask

  // One full transaction; ack_at is the REQ cycle carrying mem_ack (0 = never).
  // poke_done drives a start plus a stray ack during the done cycle.
  task automatic run_txn(input logic [5:0] op, input logic [1:0] xo, input logic [63:0] a,
                         input logic [63:0] sd, input logic [63:0] rd, input int ack_at,
                         input bit poke_done);
    bit legal, store, sgn, upd, acked;
    int nb, k, c, sh;
    logic [63:0] exp_ld, exp_be, exp_mask, exp_wd;
    logic [1:0] exp_err;
    ref_decode(op, xo, legal, store, sgn, upd, nb);
    k = int'(a % 64'd8);
    exp_ld = 64'd0; exp_be = 64'd0; exp_mask = 64'd0; exp_wd = 64'd0; exp_err = 2'd0;
    if (!legal) exp_err = 2'd2;
    else if ((a % 64'(nb)) != 64'd0) exp_err = 2'd1;
    if (legal) begin
      if (store) begin
        for (int j = 0; j < nb; j++) exp_be |= 64'd1 << (7 - (k + j));
      end else begin
        exp_be = 64'd1 << (7 - k);
      end
      for (int j = 0; j < nb; j++) begin
        sh = 56 - 8 * (k + j);
        exp_mask |= 64'hFF << sh;
        exp_wd   |= ((sd >> (8 * (nb - 1 - j))) & 64'hFF) << sh;
        exp_ld    = (exp_ld << 8) | ((rd >> sh) & 64'hFF);
      end
      if (sgn && exp_ld[8 * nb - 1]) exp_ld |= ~((64'd1 << (8 * nb)) - 64'd1);
      if (store) exp_ld = 64'd0;
    end
    start = 1'b1; opcode = op; xods = xo; ea = a; store_data = sd;
    tick();
    // scramble inputs to show the request was latched
    start = 1'b0; opcode = 6'(34); xods = 2'd1; ea = rnd64(); store_data = rnd64();
    acked = 1'b0;
    if (exp_err != 2'd0) begin
      chk("err_done", 64'(done), 64'd1);
      chk("err_code", 64'(err), 64'(exp_err));
      chk("err_noreq", 64'(mem_req), 64'd0);
      chk("err_upd", 64'(update), 64'd0);
    end else begin
      c = 1;
      while (!acked && c <= 16) begin
        chk("req", 64'(mem_req), 64'd1);
        chk("busy", 64'(busy), 64'd1);
        chk("nodone", 64'(done), 64'd0);
        chk("addr", mem_addr, a & ~64'd7);
        chk("we", 64'(mem_we), 64'(store));
        chk("be", 64'(mem_be), exp_be);
        if (store) chk("wdata", mem_wdata & exp_mask, exp_wd);
        if (c == ack_at) begin
          mem_ack = 1'b1; mem_rdata = rd; acked = 1'b1;
        end else begin
          mem_ack = 1'b0; mem_rdata = rnd64();
        end
        start = (c == 1) || ($urandom_range(0, 1) == 1);  // ignored while busy
        tick();
        c++;
      end
      mem_ack = 1'b0; start = 1'b0;
      if (acked) begin
        chk("done", 64'(done), 64'd1);
        chk("err_ok", 64'(err), 64'd0);
        chk("load_data", load_data, exp_ld);
        chk("update", 64'(update), 64'(upd));
      end else begin
        exp_err = 2'd3;
        chk("tmo_done", 64'(done), 64'd1);
        chk("tmo_err", 64'(err), 64'd3);
        chk("tmo_upd", 64'(update), 64'd0);
      end
      chk("req_drop", 64'(mem_req), 64'd0);
    end
    if (poke_done) begin
      start = 1'b1; opcode = 6'd7; mem_ack = 1'b1;
    end
    tick();
    start = 1'b0; mem_ack = 1'b0;
    chk("done_pulse", 64'(done), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_req", 64'(mem_req), 64'd0);
    chk("err_hold", 64'(err), 64'(exp_err));
    chk("upd_hold", 64'(update), 64'((exp_err == 2'd0) && upd));
    if (acked) chk("ld_hold", load_data, exp_ld);
    if (poke_done) begin
      tick();
      chk("start_at_done_ignored", 64'(done), 64'd0);
      chk("start_at_done_busy", 64'(busy), 64'd0);
    end
  endtask

  initial begin
    bit legal, store, sgn, upd;
    int nb, pick, ack_at;
    logic [5:0] op;
    logic [1:0] xo;
    logic [63:0] a;

    // reset state
    reset = 1'b1;
    tick(); tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_req", 64'(mem_req), 64'd0);
    chk("rst_we", 64'(mem_we), 64'd0);
    chk("rst_be", 64'(mem_be), 64'd0);
    chk("rst_upd", 64'(update), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_ld", load_data, 64'd0);
    chk("rst_addr", mem_addr, 64'd0);
    chk("rst_wdata", mem_wdata, 64'd0);
    reset = 1'b0;
    tick();

    // LHA sign-extended halfword at lane 2
    run_txn(6'd42, 2'd0, 64'h1002, 64'd0, 64'h0000_8001_0000_0000, 1, 1'b0);
    chk("lha_value", load_data, 64'hFFFF_FFFF_FFFF_8001);
    // STB to lane 5
    run_txn(6'd38, 2'd0, 64'h2005, 64'hAB, rnd64(), 1, 1'b0);
    // misaligned LWZ, then illegal opcode
    run_txn(6'd32, 2'd0, 64'h3002, 64'd0, 64'd0, 1, 1'b1);
    run_txn(6'd7, 2'd0, 64'h3000, 64'd0, 64'd0, 1, 1'b0);
    // LD timeout
    run_txn(6'd58, 2'd0, 64'h5000, 64'd0, 64'd0, 0, 1'b0);
    // STWU with delayed ack and start during done
    run_txn(6'd37, 2'd0, 64'h4000, 64'h1234_5678, 64'd0, 3, 1'b1);

    // stray ack while idle
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("stray_ack_done", 64'(done), 64'd0);
    chk("stray_ack_busy", 64'(busy), 64'd0);

    // reset while in REQ
    start = 1'b1; opcode = 6'd58; xods = 2'd0; ea = 64'h8;
    tick();
    start = 1'b0;
    chk("rq_req", 64'(mem_req), 64'd1);
    tick();
    reset = 1'b1;
    tick();
    chk("rq_rst_req", 64'(mem_req), 64'd0);
    chk("rq_rst_busy", 64'(busy), 64'd0);
    chk("rq_rst_done", 64'(done), 64'd0);
    reset = 1'b0;
    tick();
    chk("rq_after_done", 64'(done), 64'd0);
    chk("rq_after_req", 64'(mem_req), 64'd0);

    // randomized transactions
    for (int t = 0; t < 60; t++) begin
      pick = int'($urandom_range(0, 12));
      xo = 2'($urandom_range(0, 3));
      case (pick)
        0: op = 6'd34;
        1: op = 6'd40;
        2: op = 6'd42;
        3: op = 6'd32;
        4: begin op = 6'd58; xo = 2'd0; end
        5: begin op = 6'd58; xo = 2'd2; end
        6: op = 6'd38;
        7: op = 6'd44;
        8: op = 6'd36;
        9: op = 6'd37;
        10: begin op = 6'd62; xo = 2'd0; end
        default: op = 6'($urandom_range(0, 63));
      endcase
      ref_decode(op, xo, legal, store, sgn, upd, nb);
      a = rnd64();
      if (legal && $urandom_range(0, 3) != 0) a = a & ~64'(nb - 1);
      ack_at = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 4));
      run_txn(op, xo, a, rnd64(), rnd64(), ack_at, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
